// File: rtl/mul_scheduler.sv
// mul_scheduler: two-requester round-robin front end for an N-cycle shift-add multiplier.
// One operation per N+2 cycles: capture, N RUN cycles, FIN (DONE pulse).
module mul_scheduler #(
    parameter int N = 16
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [1:0]     REQ,
    input  logic [N-1:0]   X0,
    input  logic [N-1:0]   Y0,
    input  logic [N-1:0]   X1,
    input  logic [N-1:0]   Y1,
    output logic [1:0]     ACK,
    output logic [1:0]     DONE,
    output logic [2*N-1:0] P,
    output logic           BUSY,
    output logic           OWNER
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   x_q, x_d;
    logic [2*N-1:0] y_q, y_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;
    logic           grant;
    logic [2*N-1:0] term;

    // x shifts right and y shifts left so bit 0 of x always selects y << i
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant   = (REQ == 2'b11) ? ~last_q : REQ[1];
        term    = x_q[0] ? y_q : '0;
        case (state_q)
            S_IDLE: if (REQ != 2'b00) begin
                state_d = S_RUN;
                x_d     = grant ? X1 : X0;
                y_d     = {{N{1'b0}}, grant ? Y1 : Y0};
                acc_d   = '0;
                cnt_d   = '0;
                owner_d = grant;
                last_d  = grant;
            end
            S_RUN: begin
                acc_d = acc_q + term;
                x_d   = x_q >> 1;
                y_d   = y_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_FIN;
                    p_d     = acc_q + term;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign ACK   = (state_q == S_RUN && cnt_q == '0) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign DONE  = (state_q == S_FIN) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign BUSY  = state_q != S_IDLE;
    assign OWNER = owner_q;
    assign P     = p_q;
endmodule

// File: tb/tb_mul_scheduler.sv
// tb_mul_scheduler: directed and random operations against a product/round-robin reference model.
module tb_mul_scheduler;
    localparam int N = 16;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic [1:0]     REQ = 2'b00;
    logic [N-1:0]   X0 = '0, Y0 = '0, X1 = '0, Y1 = '0;
    logic [1:0]     ACK, DONE;
    logic [2*N-1:0] P;
    logic           BUSY, OWNER;

    int n_cmp = 0;
    int n_err = 0;
    logic           m_last = 1'b1;
    logic [2*N-1:0] m_p = '0;
    logic           m_owner = 1'b0;

    mul_scheduler #(.N(N)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
        .X0(X0), .Y0(Y0), .X1(X1), .Y1(Y1),
        .ACK(ACK), .DONE(DONE), .P(P), .BUSY(BUSY), .OWNER(OWNER)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge with DUT idle; returns at the negedge of the idle cycle after FIN.
    task automatic run_op(input logic [1:0] req, input logic [N-1:0] x0, input logic [N-1:0] y0,
                          input logic [N-1:0] x1, input logic [N-1:0] y1, input bit scramble,
                          output time ack_t);
        logic g;
        logic [1:0] oh;
        logic [63:0] prod;
        REQ = req; X0 = x0; Y0 = y0; X1 = x1; Y1 = y1;
        g = (req == 2'b11) ? ~m_last : (req == 2'b10);
        m_last = g;
        m_owner = g;
        oh = g ? 2'b10 : 2'b01;
        prod = g ? 64'(x1) * 64'(y1) : 64'(x0) * 64'(y0);
        ack_t = 0;
        @(posedge CLK);
        for (int c = 0; c <= N + 1; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                ack_t = $time;
                chk("ack", ACK, oh);
                chk("owner", OWNER, m_owner);
            end else if (c <= N) begin
                chk("ack_low", ACK, 2'b00);
            end
            if (c <= N) chk("busy", BUSY, 1'b1);
            else chk("busy_idle", BUSY, 1'b0);
            if (c == N) begin
                m_p = prod[2*N-1:0];
                chk("done", DONE, oh);
                chk("p", P, m_p);
            end else begin
                chk("done_low", DONE, 2'b00);
            end
            if (scramble && c == 3) begin
                X0 = N'($urandom); Y0 = N'($urandom);
                X1 = N'($urandom); Y1 = N'($urandom);
                REQ = 2'b00;
            end
            if (c == N) REQ = 2'b00;
        end
        chk("p_hold", P, m_p);
        chk("owner_hold", OWNER, m_owner);
    endtask

    initial begin
        time t0, t1, t2;
        bit bad;
        #1;
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_p", P, '0);
        chk("rst_ack", ACK, 2'b00);
        chk("rst_done", DONE, 2'b00);
        chk("rst_owner", OWNER, 1'b0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        run_op(2'b01, 16'd4, 16'd5, 16'd0, 16'd0, 1'b0, t0);
        run_op(2'b10, 16'd0, 16'd0, 16'd445, 16'd100, 1'b0, t0);
        chk("p_44500", P, 32'h0000ADD4);
        run_op(2'b01, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 1'b0, t0);
        chk("p_max", P, 32'hFFFE0001);
        run_op(2'b01, 16'd0, 16'd1234, 16'd0, 16'd0, 1'b0, t0);
        run_op(2'b10, 16'd0, 16'd0, 16'd3, 16'd7, 1'b1, t0);

        // request withdrawn before the edge must not start anything
        REQ = 2'b01;
        #2 REQ = 2'b00;
        @(negedge CLK);
        chk("withdrawn", BUSY, 1'b0);

        // reset mid-RUN aborts; REQ=11 afterwards must grant requester 0
        REQ = 2'b01; X0 = 16'd99; Y0 = 16'd77;
        @(posedge CLK);
        repeat (9) @(negedge CLK);
        #2 RST_N = 1'b0;
        REQ = 2'b00;
        #1;
        chk("abort_p", P, '0);
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_ack", ACK, 2'b00);
        chk("abort_done", DONE, 2'b00);
        @(negedge CLK);
        RST_N = 1'b1;
        m_last = 1'b1; m_p = '0; m_owner = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (DONE != 2'b00 || BUSY) bad = 1'b1;
        end
        chk("no_done_after_abort", bad, 1'b0);

        run_op(2'b11, 16'd11, 16'd13, 16'd17, 16'd19, 1'b0, t0);
        run_op(2'b11, 16'd11, 16'd13, 16'd17, 16'd19, 1'b0, t1);
        run_op(2'b11, 16'd11, 16'd13, 16'd17, 16'd19, 1'b0, t2);
        chk("ack_gap1", 64'(t1 - t0), 64'd180);
        chk("ack_gap2", 64'(t2 - t1), 64'd180);

        for (int i = 0; i < 12; i++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            run_op(r, N'($urandom), N'($urandom), N'($urandom), N'($urandom), 1'($urandom), t0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
